// File: rtl/alu_sequencer.sv
// Front-end controller for an 8-bit ALU: accepts one request, iterates 1-bit
// shifts by feeding Y back into A, and returns the final Y plus {N,V,C,Z}.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CNT_W-1:0] req_cnt,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [CNT_W-1:0] ONE_PASS = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_rsp_y;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_rem;

    logic       w_is_shift;
    logic [3:0] w_alu_flags;

    // Shift class: 010, 011, 100, 111; everything else completes in one pass.
    assign w_is_shift  = (r_alu_op == 3'b010) || (r_alu_op == 3'b011) ||
                         (r_alu_op == 3'b100) || (r_alu_op == 3'b111);
    assign w_alu_flags = {alu_n, alu_v, alu_c, alu_z};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_rsp_y  <= '0;
            r_flags  <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_alu_op <= req_op;
                        r_alu_a  <= req_a;
                        r_alu_b  <= req_b;
                        r_rem    <= (req_cnt == '0) ? ONE_PASS : req_cnt;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (!w_is_shift) begin
                        r_rsp_y <= alu_y;
                        r_flags <= w_alu_flags;
                        r_state <= RESP;
                    end else begin
                        r_alu_a <= alu_y;
                        if (r_rem != '0) begin
                            r_rem <= r_rem - ONE_PASS;
                        end
                        // Only the final pass's result and flags are kept.
                        if (r_rem <= ONE_PASS) begin
                            r_rsp_y <= alu_y;
                            r_flags <= w_alu_flags;
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) && rst_n;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_y     = r_rsp_y;
    assign flags     = r_flags;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer with a combinational ALU stub and
// hand-written sequences for shift feedback, response backpressure and mid-op reset.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_cnt;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       alu_n, alu_v, alu_c, alu_z;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_y;
    logic [3:0] flags;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .flags(flags), .busy(busy)
    );

    // ALU stub: add, sub (C = borrow), and, or, shl1 (C = old msb), shr1 (C = old lsb).
    logic [8:0] s_sum;
    always_comb begin
        s_sum = '0;
        alu_y = alu_a;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            3'b000: begin
                s_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = s_sum[7:0];
                alu_c = s_sum[8];
                alu_v = (alu_a[7] == alu_b[7]) && (s_sum[7] != alu_a[7]);
            end
            3'b001: begin
                s_sum = {1'b0, alu_a} - {1'b0, alu_b};
                alu_y = s_sum[7:0];
                alu_c = s_sum[8];
                alu_v = (alu_a[7] != alu_b[7]) && (s_sum[7] != alu_a[7]);
            end
            3'b101: alu_y = alu_a & alu_b;
            3'b110: alu_y = alu_a | alu_b;
            3'b010: begin alu_y = {alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
            3'b011: begin alu_y = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
            default: alu_y = alu_a;
        endcase
        alu_n = alu_y[7];
        alu_z = (alu_y == 8'h00);
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cnt;
        logic [7:0] y;
        logic [3:0] f;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] cnt);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cnt   = cnt;
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 20);
    endtask

    task automatic drain();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_idle", {30'd0, rsp_valid, busy}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{3'b000, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b1100, 1};
        vecs[1] = '{3'b010, 8'h81, 8'h00, 3'd3, 8'h08, 4'b0000, 3};
        vecs[2] = '{3'b101, 8'hF0, 8'h0F, 3'd5, 8'h00, 4'b0001, 1};
        vecs[3] = '{3'b011, 8'h01, 8'h00, 3'd0, 8'h00, 4'b0011, 1};
        vecs[4] = '{3'b001, 8'h05, 8'h07, 3'd2, 8'hFE, 4'b1010, 1};
        vecs[5] = '{3'b110, 8'h50, 8'h0A, 3'd0, 8'h5A, 4'b0000, 1};
        vecs[6] = '{3'b011, 8'h80, 8'h00, 3'd7, 8'h01, 4'b0000, 7};
        vecs[7] = '{3'b000, 8'hFF, 8'h01, 3'd1, 8'h00, 4'b0011, 1};
        vecs[8] = '{3'b010, 8'h01, 8'h00, 3'd7, 8'h80, 4'b1000, 7};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_cnt = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {alu_op, alu_a, alu_b, rsp_y, flags, rsp_valid, busy}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cnt);
            wait_rsp(lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_rsp_y", i), {24'd0, rsp_y}, {24'd0, vecs[i].y});
            check($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].f});
            drain();
        end

        // Shift feedback: alu_a walks 0x81, 0x02, 0x04 while alu_b stays put.
        issue(3'b010, 8'h81, 8'h5C, 3'd3);
        check("shl_pass1_a", {24'd0, alu_a}, 32'h81);
        @(posedge clk); #1;
        check("shl_pass2_a", {24'd0, alu_a}, 32'h02);
        @(posedge clk); #1;
        check("shl_pass3_a", {24'd0, alu_a}, 32'h04);
        check("shl_b_held", {24'd0, alu_b}, 32'h5C);
        check("shl_not_done", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("shl_done", {23'd0, rsp_valid, rsp_y}, {23'd0, 1'b1, 8'h08});
        drain();

        // Backpressure: response held, pending request not accepted until after handoff.
        issue(3'b000, 8'h7F, 8'h01, 3'd0);
        wait_rsp(lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b110; req_a = 8'h50; req_b = 8'h0A; req_cnt = 3'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_rsp", c), {19'd0, rsp_valid, req_ready, rsp_y, flags},
                  {19'd0, 1'b1, 1'b0, 8'h80, 4'b1100});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("handoff_no_accept", {30'd0, rsp_valid, busy}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("accept_after_idle", {28'd0, busy, alu_op}, {28'd0, 1'b1, 3'b110});
        req_valid = 1'b0;
        wait_rsp(lat);
        check("held_req_result", {23'd0, rsp_valid, rsp_y}, {23'd0, 1'b1, 8'h5A});
        check("flags_after_held", {28'd0, flags}, 32'd0);
        drain();

        // Mid-operation reset: leave nonzero flags behind, then abort a 7-pass shift.
        issue(3'b000, 8'hFF, 8'h01, 3'd0);
        wait_rsp(lat);
        check("pre_abort_flags", {28'd0, flags}, 32'b0011);
        drain();
        issue(3'b010, 8'h01, 8'h00, 3'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_progress", {23'd0, busy, alu_a}, {23'd0, 1'b1, 8'h04});
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {11'd0, rsp_valid, busy, req_ready, flags, rsp_y, alu_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_response", seen, 0);
        check("abort_idle", {30'd0, busy, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
